// File: rtl/n64adv_vout_pkg.sv
// Shared constants for the N64Adv video output stage.
// Sync bit positions, filter codes and the filter-request mapping.
package n64adv_vout_pkg;

    localparam int SYNC_V = 3;
    localparam int SYNC_B = 2;
    localparam int SYNC_H = 1;
    localparam int SYNC_C = 0;

    localparam logic [1:0] FILT_SD  = 2'b00;
    localparam logic [1:0] FILT_ED  = 2'b01;
    localparam logic [1:0] FILT_HD  = 2'b10;
    localparam logic [1:0] FILT_BYP = 2'b11;

    // cfg: 00 auto, 01 9.5 MHz, 10 18 MHz, 11 bypass
    function automatic logic [1:0] filt_req(
        input logic [1:0] cfg,
        input logic       linedbl
    );
        logic [1:0] code;
        unique case (cfg)
            2'b11:   code = FILT_BYP;
            2'b10:   code = FILT_ED;
            2'b01:   code = FILT_SD;
            default: code = linedbl ? FILT_ED : FILT_SD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/n64adv_vout_dline.sv
// Shift register of D registered taps with an indexed read-out.
// Ports: clk, rst_n, din (tap 0), sel (tap index), dout (selected tap).
module n64adv_vout_dline
    import n64adv_vout_pkg::*;
#(
    parameter int W = 24,
    parameter int D = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [W-1:0]           din,
    input  logic [$clog2(D+1)-1:0] sel,
    output logic [W-1:0]           dout
);

    localparam int SW = $clog2(D+1);

    logic [W-1:0] q [1:D];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i <= D; i++) q[i] <= '0;
        end else begin
            q[1] <= din;
            for (int i = 2; i <= D; i++) q[i] <= q[i-1];
        end
    end

    always_comb begin
        dout = din;
        for (int i = 1; i <= D; i++)
            if (sel == SW'(i)) dout = q[i];
    end

endmodule

// File: rtl/n64adv_vout_stage.sv
// Final N64Adv output stage: colour/sync alignment, CSYNC and filter pins.
// Ports: VCLK/nRST, vdata_i/sync_i in, config in, VD_o/nCSYNC/pin muxes out.
module n64adv_vout_stage
    import n64adv_vout_pkg::*;
#(
    parameter int COLOR_W      = 8,
    parameter int N_CH         = 3,
    parameter int MAX_DLY      = 4,
    parameter int FILT_TIMEOUT = 2**20
) (
    input  logic                         VCLK,
    input  logic                         nRST,
    input  logic [N_CH*COLOR_W-1:0]      vdata_i,
    input  logic [3:0]                   sync_i,
    input  logic [$clog2(MAX_DLY+1)-1:0] dly_sel,
    input  logic                         linedbl_en,
    input  logic [1:0]                   cfg_filter,
    input  logic                         csync_on_dac,
    input  logic                         use_vga_hvsync,
    output logic [N_CH*COLOR_W-1:0]      VD_o,
    output logic [1:0]                   nCSYNC,
    output logic                         nVSYNC_or_F2,
    output logic                         nHSYNC_or_F1
);

    localparam int VW = N_CH*COLOR_W;
    localparam int DW = $clog2(MAX_DLY+1);
    localparam int MW = $clog2(MAX_DLY+2);
    localparam int TW = $clog2(FILT_TIMEOUT);

    localparam logic [DW-1:0] DLY_MAX = DW'(MAX_DLY);
    localparam logic [MW-1:0] MUTE_LD = MW'(MAX_DLY+1);
    localparam logic [TW-1:0] TO_MAX  = TW'(FILT_TIMEOUT-1);

    logic [3:0]    sync_o;
    logic [DW-1:0] dly_clamp;
    logic [DW-1:0] dly_applied;
    logic [MW-1:0] mute_cnt;
    logic [VW-1:0] tap;
    logic          vs_q;
    logic          vs_fall;
    logic [TW-1:0] to_cnt;
    logic          to_hit;
    logic          commit;
    logic [2:1]    filter;

    assign dly_clamp = (dly_sel > DLY_MAX) ? DLY_MAX : dly_sel;

    n64adv_vout_dline #(
        .W (VW),
        .D (MAX_DLY)
    ) u_dline (
        .clk  (VCLK),
        .rst_n(nRST),
        .din  (vdata_i),
        .sel  (dly_applied),
        .dout (tap)
    );

    always_ff @(posedge VCLK or negedge nRST) begin
        if (!nRST) begin
            sync_o      <= '0;
            VD_o        <= '0;
            dly_applied <= '0;
            mute_cnt    <= '0;
        end else begin
            sync_o <= sync_i;
            VD_o   <= (mute_cnt != '0) ? '0 : tap;
            // the new tap holds stale data until it refills
            if (dly_clamp != dly_applied) begin
                dly_applied <= dly_clamp;
                mute_cnt    <= MUTE_LD;
            end else if (mute_cnt != '0) begin
                mute_cnt <= mute_cnt - 1'b1;
            end
        end
    end

    assign to_hit = (to_cnt == TO_MAX);
    assign commit = vs_fall | to_hit;

    always_ff @(posedge VCLK or negedge nRST) begin
        if (!nRST) begin
            vs_q    <= 1'b1;
            vs_fall <= 1'b0;
            to_cnt  <= '0;
            filter  <= FILT_SD;
        end else begin
            vs_q    <= sync_i[SYNC_V];
            vs_fall <= vs_q & ~sync_i[SYNC_V];
            if (commit) begin
                filter <= filt_req(cfg_filter, linedbl_en);
                to_cnt <= '0;
            end else if (!to_hit) begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

    assign nCSYNC = {sync_o[SYNC_C],
                     csync_on_dac ? sync_o[SYNC_C] : 1'b0};

    assign nVSYNC_or_F2 = use_vga_hvsync ? sync_o[SYNC_V] : filter[2];
    assign nHSYNC_or_F1 = use_vga_hvsync ? sync_o[SYNC_H] : filter[1];

endmodule

// File: tb/tb_n64adv_vout_stage.sv
// Bench for n64adv_vout_stage: cycle model plus directed literal checks.
// Drives inputs 2 time units after each rising edge, compares on falling edges.
module tb_n64adv_vout_stage;

    localparam int MD = 4;
    localparam int FT = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [23:0] vdata_i = '0;
    logic [3:0]  sync_i = 4'hF;
    logic [2:0]  dly_sel = '0;
    logic        linedbl_en = 1'b0;
    logic [1:0]  cfg_filter = 2'b00;
    logic        csync_on_dac = 1'b1;
    logic        use_vga_hvsync = 1'b1;
    logic [23:0] VD_o;
    logic [1:0]  nCSYNC;
    logic        nVSYNC_or_F2;
    logic        nHSYNC_or_F1;

    int n_cmp = 0;
    int n_bad = 0;
    logic chk_en = 1'b0;

    n64adv_vout_stage #(
        .COLOR_W     (8),
        .N_CH        (3),
        .MAX_DLY     (MD),
        .FILT_TIMEOUT(FT)
    ) dut (
        .VCLK          (clk),
        .nRST          (rst_n),
        .vdata_i       (vdata_i),
        .sync_i        (sync_i),
        .dly_sel       (dly_sel),
        .linedbl_en    (linedbl_en),
        .cfg_filter    (cfg_filter),
        .csync_on_dac  (csync_on_dac),
        .use_vga_hvsync(use_vga_hvsync),
        .VD_o          (VD_o),
        .nCSYNC        (nCSYNC),
        .nVSYNC_or_F2  (nVSYNC_or_F2),
        .nHSYNC_or_F1  (nHSYNC_or_F1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [23:0] ramp(input int i);
        return 24'hA00000 + 24'(i) * 24'h000101;
    endfunction

    function automatic logic [1:0] req(input logic [1:0] c, input logic l);
        if (c == 2'b11) return 2'b11;
        if (c == 2'b10) return 2'b01;
        if (c == 2'b01) return 2'b00;
        return l ? 2'b01 : 2'b00;
    endfunction

    // model state: edge counter, input history, event timestamps
    int          k = 0;
    logic [23:0] hist[$];
    logic        vsh[$];
    int          m_dly = 0;
    int          last_change = -1000;
    int          last_commit = 0;
    logic [1:0]  m_filt = 2'b00;
    logic [3:0]  exp_sync = 4'h0;
    logic [23:0] exp_vd = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k = 0;
            hist.delete();
            for (int i = 0; i < MD; i++) hist.push_front(24'h0);
            vsh.delete();
            vsh.push_front(1'b1);
            vsh.push_front(1'b1);
            m_dly = 0;
            last_change = -1000;
            last_commit = 0;
            m_filt = 2'b00;
            exp_sync = 4'h0;
            exp_vd = '0;
        end else begin
            int cl;
            logic fell;
            k++;
            hist.push_front(vdata_i);
            if (hist.size() > MD + 1) void'(hist.pop_back());
            if (k - last_change >= 1 && k - last_change <= MD + 1)
                exp_vd = '0;
            else
                exp_vd = hist[m_dly];
            cl = (int'(dly_sel) > MD) ? MD : int'(dly_sel);
            if (cl != m_dly) begin
                m_dly = cl;
                last_change = k;
            end
            vsh.push_front(sync_i[3]);
            if (vsh.size() > 3) void'(vsh.pop_back());
            fell = (vsh[1] == 1'b0) && (vsh[2] == 1'b1);
            if (fell || (k - last_commit == FT)) begin
                m_filt = req(cfg_filter, linedbl_en);
                last_commit = k;
            end
            exp_sync = sync_i;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_vd", VD_o, exp_vd);
            chk("m_csync", nCSYNC,
                {exp_sync[0], csync_on_dac & exp_sync[0]});
            chk("m_pinv", nVSYNC_or_F2,
                use_vga_hvsync ? exp_sync[3] : m_filt[1]);
            chk("m_pinh", nHSYNC_or_F1,
                use_vga_hvsync ? exp_sync[1] : m_filt[0]);
        end
    end

    logic [1:0] filt_pins;
    assign filt_pins = {nVSYNC_or_F2, nHSYNC_or_F1};

    initial begin
        #3 rst_n = 1'b0;
        chk_en = 1'b1;
        #1;
        chk("rst_vd", VD_o, 24'h0);
        chk("rst_csync", nCSYNC, 2'b00);
        chk("rst_pinv", nVSYNC_or_F2, 1'b0);
        chk("rst_pinh", nHSYNC_or_F1, 1'b0);
        step();
        step();
        rst_n = 1'b1;

        vdata_i = 24'h123456;
        sync_i = 4'b1101;
        step();
        chk("t1_vd", VD_o, 24'h123456);
        chk("t1_csync", nCSYNC, 2'b11);
        chk("t1_pinv", nVSYNC_or_F2, 1'b1);
        chk("t1_pinh", nHSYNC_or_F1, 1'b0);
        sync_i = 4'hF;

        dly_sel = 3'd3;
        for (int i = 0; i < 12; i++) begin
            vdata_i = ramp(i);
            step();
            if (i == 0)      chk("d3_first", VD_o, ramp(0));
            else if (i <= 5) chk("d3_mute", VD_o, 24'h0);
            else             chk("d3_lag", VD_o, ramp(i - 3));
        end

        dly_sel = 3'd7;
        for (int i = 12; i < 28; i++) begin
            vdata_i = ramp(i);
            step();
            if (i >= 13 && i <= 17) chk("d7_mute", VD_o, 24'h0);
            else if (i >= 18)       chk("d7_lag", VD_o, ramp(i - 4));
        end

        dly_sel = 3'd0;
        vdata_i = ramp(28);
        step();
        vdata_i = ramp(29);
        step();
        rst_n = 1'b0;
        #1;
        chk("rm_vd", VD_o, 24'h0);
        chk("rm_csync", nCSYNC, 2'b00);
        chk("rm_pinv", nVSYNC_or_F2, 1'b0);
        step();
        rst_n = 1'b1;
        for (int i = 30; i < 33; i++) begin
            vdata_i = ramp(i);
            step();
            chk("rm_nomute", VD_o, ramp(i));
        end

        use_vga_hvsync = 1'b0;
        cfg_filter = 2'b00;
        linedbl_en = 1'b1;
        step();
        step();
        chk("f_hold", filt_pins, 2'b00);
        sync_i[3] = 1'b0;
        step();
        chk("f_e1", filt_pins, 2'b00);
        sync_i[3] = 1'b1;
        step();
        chk("f_e2", filt_pins, 2'b01);

        cfg_filter = 2'b11;
        linedbl_en = 1'b0;
        for (int i = 0; i < 15; i++) step();
        chk("to_wait", filt_pins, 2'b01);
        step();
        chk("to_hit", filt_pins, 2'b11);

        cfg_filter = 2'b10;
        for (int i = 0; i < 14; i++) step();
        sync_i[3] = 1'b0;
        step();
        chk("co_pre", filt_pins, 2'b11);
        step();
        chk("co_hit", filt_pins, 2'b01);
        cfg_filter = 2'b11;
        for (int i = 0; i < 15; i++) step();
        chk("co_wait", filt_pins, 2'b01);
        step();
        chk("co_next", filt_pins, 2'b11);

        use_vga_hvsync = 1'b1;
        csync_on_dac = 1'b0;
        sync_i = 4'b0110;
        step();
        chk("p_csync0", nCSYNC, 2'b00);
        chk("p_pinv0", nVSYNC_or_F2, 1'b0);
        chk("p_pinh0", nHSYNC_or_F1, 1'b1);
        sync_i = 4'b1001;
        step();
        chk("p_csync1", nCSYNC, 2'b10);
        chk("p_pinv1", nVSYNC_or_F2, 1'b1);
        chk("p_pinh1", nHSYNC_or_F1, 1'b0);
        use_vga_hvsync = 1'b0;
        #1;
        chk("p_filt", filt_pins, 2'b11);
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
